// File: rtl/track_formatter_ctrl.sv
// Track packet formatter control: sequences track, hit and end-event words into the output FIFO.
// Optional FMT_WORDCOUNT_EN adds WORD_COUNT, the words written up to and including each end-event word.
module track_formatter_ctrl #(
    parameter int NTRK_WORDS = 2,
    parameter int NHITCH     = 6,
    parameter int SEL_W      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              TRACK_FIFO_EMPTY,
    output logic              TRACK_FIFO_RE,
    input  logic              EE_FIFO_EMPTY,
    output logic              FIFO_EE_RE,
    output logic [NHITCH-1:0] HITS_FIFO_RE,
    input  logic              OUT_FIFO_FULL,
    output logic              OUT_FIFO_WE,
    output logic              OUT_FIFO_ERROR,
    output logic [SEL_W-1:0]  SEL,
    output logic              EE_OUT,
    output logic              EP_OUT
`ifdef FMT_WORDCOUNT_EN
    ,
    output logic [11:0]       WORD_COUNT
`endif
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TRK  = 3'd1;
    localparam logic [2:0] ST_HIT  = 3'd2;
    localparam logic [2:0] ST_EEW  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  r_slot;
    logic [15:0] r_stall;
    logic        w_active;
    logic        w_wr;
    logic        w_trk_last;
    logic        w_hit_last;

    assign w_active   = (r_state == ST_TRK) || (r_state == ST_HIT) || (r_state == ST_EEW);
    assign w_wr       = w_active && !OUT_FIFO_FULL;
    assign w_trk_last = (r_slot == 3'(NTRK_WORDS - 1));
    assign w_hit_last = (r_slot == 3'(NHITCH - 1));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            r_stall <= '0;
        end else if (r_state == ST_IDLE) begin
            r_stall <= '0;
            r_slot  <= '0;
            if (!TRACK_FIFO_EMPTY)
                r_state <= ST_TRK;
            else if (!EE_FIFO_EMPTY)
                r_state <= ST_EEW;
        end else if (w_active) begin
            if (OUT_FIFO_FULL) begin
                // Stall counts the current full cycle, so the TIMEOUT-th consecutive one trips the error.
                r_stall <= r_stall + 16'd1;
                if (r_stall >= 16'(TIMEOUT - 1))
                    r_state <= ST_ERR;
            end else begin
                r_stall <= '0;
                if (r_state == ST_TRK) begin
                    r_slot  <= w_trk_last ? 3'd0 : r_slot + 3'd1;
                    r_state <= w_trk_last ? ST_HIT : ST_TRK;
                end else if (r_state == ST_HIT) begin
                    r_slot  <= w_hit_last ? 3'd0 : r_slot + 3'd1;
                    r_state <= w_hit_last ? ST_IDLE : ST_HIT;
                end else begin
                    r_slot  <= '0;
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        SEL = '0;
        case (r_state)
            ST_TRK:  SEL = SEL_W'(r_slot);
            ST_HIT:  SEL = SEL_W'(NTRK_WORDS) + SEL_W'(r_slot);
            ST_EEW:  SEL = SEL_W'(NTRK_WORDS + NHITCH);
            default: SEL = '0;
        endcase
    end

    always_comb begin
        HITS_FIFO_RE = '0;
        for (int unsigned c = 0; c < NHITCH; c++) begin
            if (w_wr && (r_state == ST_HIT) && (r_slot == 3'(c)))
                HITS_FIFO_RE[c] = 1'b1;
        end
    end

    assign OUT_FIFO_WE    = w_wr;
    assign TRACK_FIFO_RE  = w_wr && (r_state == ST_TRK) && w_trk_last;
    assign EP_OUT         = w_wr && (r_state == ST_HIT) && w_hit_last;
    assign EE_OUT         = w_wr && (r_state == ST_EEW);
    assign FIFO_EE_RE     = EE_OUT;
    assign OUT_FIFO_ERROR = (r_state == ST_ERR);

`ifdef FMT_WORDCOUNT_EN
    logic [11:0] r_acc;
    logic [11:0] r_word_count;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_acc        <= '0;
            r_word_count <= '0;
        end else if (w_wr) begin
            if (r_state == ST_EEW) begin
                r_word_count <= (r_acc == '1) ? '1 : r_acc + 12'd1;
                r_acc        <= '0;
            end else if (r_acc != '1) begin
                r_acc <= r_acc + 12'd1;
            end
        end
    end

    assign WORD_COUNT = r_word_count;
`endif

endmodule

// File: tb/tb_track_formatter_ctrl.sv
// Self-checking bench for track_formatter_ctrl: directed table, corner sequences and random traffic
// against a word-stream reference model.
module tb_track_formatter_ctrl;

    localparam int NTRK = 2;
    localparam int NH   = 6;
    localparam int TO   = 4;

    logic          CLOCK;
    logic          RESET_N;
    logic          TRACK_FIFO_EMPTY;
    logic          TRACK_FIFO_RE;
    logic          EE_FIFO_EMPTY;
    logic          FIFO_EE_RE;
    logic [NH-1:0] HITS_FIFO_RE;
    logic          OUT_FIFO_FULL;
    logic          OUT_FIFO_WE;
    logic          OUT_FIFO_ERROR;
    logic [3:0]    SEL;
    logic          EE_OUT;
    logic          EP_OUT;
`ifdef FMT_WORDCOUNT_EN
    logic [11:0]   WORD_COUNT;
`endif

    track_formatter_ctrl #(
        .NTRK_WORDS(NTRK),
        .NHITCH    (NH),
        .SEL_W     (4),
        .TIMEOUT   (TO)
    ) dut (
        .CLOCK           (CLOCK),
        .RESET_N         (RESET_N),
        .TRACK_FIFO_EMPTY(TRACK_FIFO_EMPTY),
        .TRACK_FIFO_RE   (TRACK_FIFO_RE),
        .EE_FIFO_EMPTY   (EE_FIFO_EMPTY),
        .FIFO_EE_RE      (FIFO_EE_RE),
        .HITS_FIFO_RE    (HITS_FIFO_RE),
        .OUT_FIFO_FULL   (OUT_FIFO_FULL),
        .OUT_FIFO_WE     (OUT_FIFO_WE),
        .OUT_FIFO_ERROR  (OUT_FIFO_ERROR),
        .SEL             (SEL),
        .EE_OUT          (EE_OUT),
        .EP_OUT          (EP_OUT)
`ifdef FMT_WORDCOUNT_EN
        ,
        .WORD_COUNT      (WORD_COUNT)
`endif
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of SEL values still to be written, plus stall/error/word-count state.
    int q[$];
    int m_stall = 0;
    bit m_err   = 0;
    int m_acc   = 0;
    int m_wc    = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_step(bit te, bit ee, bit full);
        int s;
        bit we, tre, eeo, ep;
        int sel, hits;
        we = 0; tre = 0; eeo = 0; ep = 0; sel = 0; hits = 0;
        if (!m_err && q.size() > 0) begin
            s   = q[0];
            sel = s;
            if (!full) begin
                we  = 1;
                tre = (s == NTRK - 1);
                if (s >= NTRK && s < NTRK + NH) hits = 1 << (s - NTRK);
                ep  = (s == NTRK + NH - 1);
                eeo = (s == NTRK + NH);
            end
        end
        chk("we", 32'(OUT_FIFO_WE), 32'(we));
        chk("sel", 32'(SEL), 32'(sel));
        chk("track_re", 32'(TRACK_FIFO_RE), 32'(tre));
        chk("hits_re", 32'(HITS_FIFO_RE), 32'(hits));
        chk("ee_out", 32'(EE_OUT), 32'(eeo));
        chk("ee_re", 32'(FIFO_EE_RE), 32'(eeo));
        chk("ep_out", 32'(EP_OUT), 32'(ep));
        chk("error", 32'(OUT_FIFO_ERROR), 32'(m_err));
`ifdef FMT_WORDCOUNT_EN
        chk("word_count", 32'(WORD_COUNT), 32'(m_wc));
`endif
        if (m_err) begin
        end else if (q.size() == 0) begin
            if (!te) begin
                for (int k = 0; k < NTRK + NH; k++) q.push_back(k);
            end else if (!ee) begin
                q.push_back(NTRK + NH);
            end
        end else if (full) begin
            m_stall++;
            if (m_stall >= TO) begin
                m_err = 1;
                q.delete();
            end
        end else begin
            m_stall = 0;
            void'(q.pop_front());
            if (eeo) begin
                m_wc  = (m_acc + 1 > 4095) ? 4095 : m_acc + 1;
                m_acc = 0;
            end else if (m_acc < 4095) begin
                m_acc++;
            end
        end
    endfunction

    task automatic step(input bit te, input bit ee, input bit full);
        @(negedge CLOCK);
        TRACK_FIFO_EMPTY = te;
        EE_FIFO_EMPTY    = ee;
        OUT_FIFO_FULL    = full;
        #1;
        model_step(te, ee, full);
    endtask

    task automatic do_reset();
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_we", 32'(OUT_FIFO_WE), 0);
        chk("rst_sel", 32'(SEL), 0);
        chk("rst_res", 32'({TRACK_FIFO_RE, FIFO_EE_RE, HITS_FIFO_RE}), 0);
        chk("rst_flags", 32'({EE_OUT, EP_OUT, OUT_FIFO_ERROR}), 0);
        q.delete();
        m_stall = 0; m_err = 0; m_acc = 0; m_wc = 0;
        TRACK_FIFO_EMPTY = 1'b1;
        EE_FIFO_EMPTY    = 1'b1;
        OUT_FIFO_FULL    = 1'b0;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    typedef struct {
        bit te, ee, full;
        bit we;
        int sel;
        bit tre;
        int hits;
        bit eeo, ep;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(bit te, bit ee, bit full, bit we, int sel, bit tre, int hits, bit eeo, bit ep);
        vec_t v;
        v.te = te; v.ee = ee; v.full = full; v.we = we; v.sel = sel;
        v.tre = tre; v.hits = hits; v.eeo = eeo; v.ep = ep;
        return v;
    endfunction

    initial begin
        RESET_N          = 1'b0;
        TRACK_FIFO_EMPTY = 1'b1;
        EE_FIFO_EMPTY    = 1'b1;
        OUT_FIFO_FULL    = 1'b0;

        // One track then a pending end-event; the track FIFO empties after its pop.
        tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 0);
        tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0,  0, 0);
        tbl[2]  = mk(1, 0, 0, 1, 1, 1, 0,  0, 0);
        tbl[3]  = mk(1, 0, 0, 1, 2, 0, 1,  0, 0);
        tbl[4]  = mk(1, 0, 0, 1, 3, 0, 2,  0, 0);
        tbl[5]  = mk(1, 0, 0, 1, 4, 0, 4,  0, 0);
        tbl[6]  = mk(1, 0, 0, 1, 5, 0, 8,  0, 0);
        tbl[7]  = mk(1, 0, 0, 1, 6, 0, 16, 0, 0);
        tbl[8]  = mk(1, 0, 0, 1, 7, 0, 32, 0, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0);
        tbl[10] = mk(1, 1, 0, 1, 8, 0, 0,  1, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 0,  0, 0);

        #1;
        chk("init_we", 32'(OUT_FIFO_WE), 0);
        chk("init_err", 32'(OUT_FIFO_ERROR), 0);
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].te, tbl[i].ee, tbl[i].full);
            chk("tbl_we", 32'(OUT_FIFO_WE), 32'(tbl[i].we));
            chk("tbl_sel", 32'(SEL), 32'(tbl[i].sel));
            chk("tbl_tre", 32'(TRACK_FIFO_RE), 32'(tbl[i].tre));
            chk("tbl_hits", 32'(HITS_FIFO_RE), 32'(tbl[i].hits));
            chk("tbl_ee", 32'({EE_OUT, FIFO_EE_RE}), tbl[i].eeo ? 32'd3 : 32'd0);
            chk("tbl_ep", 32'(EP_OUT), 32'(tbl[i].ep));
        end
`ifdef FMT_WORDCOUNT_EN
        chk("wc_nine", 32'(WORD_COUNT), 32'd9);
`endif

        // Output stall of 3 cycles at SEL=4, then resume at the same word.
        step(0, 1, 0);
        repeat (4) step(1, 1, 0);
        repeat (3) begin
            step(1, 1, 1);
            chk("stall_we", 32'(OUT_FIFO_WE), 0);
            chk("stall_sel", 32'(SEL), 4);
            chk("stall_re", 32'({TRACK_FIFO_RE, FIFO_EE_RE, HITS_FIFO_RE}), 0);
        end
        step(1, 1, 0);
        chk("resume_we", 32'(OUT_FIFO_WE), 1);
        chk("resume_sel", 32'(SEL), 4);
        chk("resume_hit", 32'(HITS_FIFO_RE), 32'd4);
        repeat (4) step(1, 1, 0);

        // Timeout: full held TO cycles in HIT latches the error.
        step(0, 1, 0);
        repeat (3) step(1, 1, 0);
        repeat (TO) step(1, 1, 1);
        step(0, 0, 0);
        chk("to_err", 32'(OUT_FIFO_ERROR), 1);
        repeat (3) begin
            step(0, 0, 0);
            chk("to_no_we", 32'(OUT_FIFO_WE), 0);
        end

        // Reset mid-packet at SEL=5, then a fresh track starts at SEL=0.
        do_reset();
        step(0, 1, 0);
        repeat (6) step(1, 1, 0);
        chk("pre_rst_sel", 32'(SEL), 5);
        do_reset();
        step(0, 1, 0);
        step(1, 1, 0);
        chk("restart_sel", 32'(SEL), 0);
        chk("restart_we", 32'(OUT_FIFO_WE), 1);

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if (m_err && $urandom_range(0, 9) == 0) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/track_formatter_ctrl.md
TRACK_FORMATTER_CTRL -- requirements
Module: track_formatter_ctrl

Interface
REQ-001 Parameter NTRK_WORDS, default 2, number of track-parameter words per track (1..7).
REQ-002 Parameter NHITCH, default 6, number of hit channels, one hit word each per track (1..8).
REQ-003 Parameter SEL_W, default 4, SEL width; SHALL satisfy 2^SEL_W > NTRK_WORDS+NHITCH.
REQ-004 Parameter TIMEOUT, default 255, consecutive OUT_FIFO_FULL cycles tolerated before error (1..65535).
REQ-005 CLOCK  in  1  single clock; all state on rising edge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 TRACK_FIFO_EMPTY  in  1  track FIFO (first-word-fall-through) empty.
REQ-008 TRACK_FIFO_RE  out  1  track FIFO read/pop.
REQ-009 EE_FIFO_EMPTY  in  1  end-event FIFO empty.
REQ-010 FIFO_EE_RE  out  1  end-event FIFO pop.
REQ-011 HITS_FIFO_RE  out  NHITCH  one-hot hit FIFO pop, bit c = channel c.
REQ-012 OUT_FIFO_FULL  in  1  output FIFO full.
REQ-013 OUT_FIFO_WE  out  1  output FIFO write.
REQ-014 OUT_FIFO_ERROR  out  1  sticky output-stall timeout.
REQ-015 SEL  out  SEL_W  output data mux select.
REQ-016 EE_OUT  out  1  current written word is the end-event word.
REQ-017 EP_OUT  out  1  current written word is last word of a track packet.

Function
REQ-018 FSM states IDLE, TRK, HIT, EEW, ERR; slot counter selects word within TRK/HIT.
REQ-019 IDLE: TRACK_FIFO_EMPTY=0 -> TRK slot 0; else EE_FIFO_EMPTY=0 -> EEW; else stay. Tracks SHALL win when both pending.
REQ-020 TRK slot k (0..NTRK_WORDS-1): SEL=k; TRACK_FIFO_RE=1 only on slot NTRK_WORDS-1 write; then HIT slot 0.
REQ-021 HIT slot c (0..NHITCH-1): SEL=NTRK_WORDS+c, HITS_FIFO_RE[c]=1 with the write; after c=NHITCH-1 -> IDLE.
REQ-022 EP_OUT=1 only with the HIT slot NHITCH-1 write.
REQ-023 EEW: SEL=NTRK_WORDS+NHITCH, EE_OUT=1, FIFO_EE_RE=1 with the write, then -> IDLE.
REQ-024 A slot write occurs when in TRK/HIT/EEW and OUT_FIFO_FULL=0: OUT_FIFO_WE=1, slot advances next cycle; one word per cycle sustained.
REQ-025 OUT_FIFO_FULL=1: OUT_FIFO_WE, all RE, EE_OUT, EP_OUT =0; SEL and slot held.
REQ-026 WE/RE/EE_OUT/EP_OUT combinational from registered state/slot and OUT_FIFO_FULL; SEL=0 in IDLE/ERR.
REQ-027 Stall counter counts consecutive full cycles in TRK/HIT/EEW, clears on any write; reaching TIMEOUT -> ERR, OUT_FIFO_ERROR=1.
REQ-028 ERR: no writes, no reads, held until reset.
REQ-029 Mid-packet TRACK_FIFO_EMPTY changes SHALL be ignored; packet always completes.
REQ-030 Never more than one RE bit asserted per cycle.

Reset
REQ-031 RESET_N=0 asynchronously: state IDLE, slot 0, stall counter 0, OUT_FIFO_ERROR=0, all outputs 0, mid-packet included.
REQ-032 First transition possible on the first rising edge after RESET_N deasserts.

Configuration
REQ-033 Macro FMT_WORDCOUNT_EN defined: extra output WORD_COUNT[11:0], count of words written since last EE word including it, updated on EEW write, counter saturates at 4095, reset 0.
REQ-034 FMT_WORDCOUNT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-035 Defaults, one track, full=0: 8 consecutive WE, SEL 0..7, TRACK_FIFO_RE at SEL=1, HITS_FIFO_RE=000001..100000, EP_OUT at SEL=7.
REQ-036 Track then EE pending (EE_FIFO_EMPTY=0), track FIFO empties: 8 track words then one word SEL=8, EE_OUT=1, FIFO_EE_RE=1; WORD_COUNT=9 if enabled.
REQ-037 OUT_FIFO_FULL=1 for 3 cycles at SEL=4: WE=0, SEL held 4, no RE; resumes SEL=4 write on release, no lost or duplicated word.
REQ-038 TIMEOUT=4, full held 4 cycles in HIT: OUT_FIFO_ERROR=1, no further WE even after full drops.
REQ-039 RESET_N low at SEL=5: all outputs 0 immediately; after release, new track restarts at SEL=0.
